// File: rtl/lc3_mmio_responder.sv
// LC-3 memory-mapped I/O responder: address decode, keyboard/display device
// registers, memory-array enable and the R ready handshake for the control FSM.
module lc3_mmio_responder #(
    parameter int MEM_LATENCY = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        MIO_EN,
    input  logic        R_W,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR_IN,
    output logic [1:0]  INMUX_SEL,
    output logic        MEM_EN,
    output logic        MEM_WE,
    output logic        R,
    output logic [15:0] KBSR_OUT,
    output logic [15:0] KBDR_OUT,
    output logic [15:0] DSR_OUT,
    input  logic [7:0]  KB_DATA,
    input  logic        KB_VALID,
    output logic        KB_READY,
    output logic [7:0]  DISP_DATA,
    output logic        DISP_VALID,
    input  logic        DISP_READY,
    output logic        KB_INT,
    output logic        DISP_INT
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic       LAT_ONE  = (MEM_LATENCY == 32'sd1);
    localparam logic [3:0] CNT_INIT = (MEM_LATENCY > 32'sd1) ? 4'(MEM_LATENCY - 32'sd2) : 4'd0;

    // Device register index carried through the access: MAR[2:1]
    localparam logic [1:0] IDX_KBSR = 2'd0;
    localparam logic [1:0] IDX_KBDR = 2'd1;
    localparam logic [1:0] IDX_DSR  = 2'd2;
    localparam logic [1:0] IDX_DDR  = 2'd3;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        is_dev_q, is_dev_d;
    logic [1:0]  idx_q, idx_d;
    logic        rw_q, rw_d;
    logic        r_q, r_d;
    logic        mem_we_q, mem_we_d;

    logic        kb_full_q, kb_full_d;
    logic        kb_ie_q, kb_ie_d;
    logic [7:0]  kbdr_q, kbdr_d;
    logic        dsr_rdy_q, dsr_rdy_d;
    logic        dsr_ie_q, dsr_ie_d;
    logic [7:0]  disp_data_q, disp_data_d;
    logic        disp_valid_q, disp_valid_d;
    logic        kb_int_q, kb_int_d;
    logic        disp_int_q, disp_int_d;

    logic        is_dev_addr_s;
    logic        dev_rd_s;
    logic        dev_wr_s;
    logic        unused_mdr_s;

    assign unused_mdr_s = ^{MDR_IN[15], MDR_IN[13:8]};

    // Combinational address decode for the CPU-side mux and memory enable
    always_comb begin
        is_dev_addr_s = (MAR[15:3] == 13'h1FC0) && (MAR[0] == 1'b0);
        case (MAR)
            16'hFE02: INMUX_SEL = 2'b00;
            16'hFE00: INMUX_SEL = 2'b01;
            16'hFE04: INMUX_SEL = 2'b10;
            default:  INMUX_SEL = 2'b11;
        endcase
        MEM_EN   = MIO_EN & ~is_dev_addr_s;
        KB_READY = ~kb_full_q;
    end

    // Access FSM next state and latched decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_dev_d = is_dev_q;
        idx_d    = idx_q;
        rw_d     = rw_q;
        case (state_q)
            ST_IDLE: begin
                if (MIO_EN) begin
                    is_dev_d = is_dev_addr_s;
                    idx_d    = MAR[2:1];
                    rw_d     = R_W;
                    if (is_dev_addr_s || LAT_ONE) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        r_d      = (state_d == ST_DONE);
        mem_we_d = (state_d == ST_DONE) & ~is_dev_d & rw_d;
    end

    // Device register updates; all access side effects land on the edge ending DONE
    always_comb begin
        dev_rd_s = (state_q == ST_DONE) & is_dev_q & ~rw_q;
        dev_wr_s = (state_q == ST_DONE) & is_dev_q & rw_q;

        kb_full_d    = kb_full_q;
        kb_ie_d      = kb_ie_q;
        kbdr_d       = kbdr_q;
        dsr_rdy_d    = dsr_rdy_q;
        dsr_ie_d     = dsr_ie_q;
        disp_data_d  = disp_data_q;
        disp_valid_d = disp_valid_q;

        if (dev_rd_s && (idx_q == IDX_KBDR)) begin
            kb_full_d = 1'b0;
        end else begin
            kb_full_d = kb_full_q;
        end
        // Capture uses the pre-edge ready, so it never races a same-edge clear
        if (KB_VALID && !kb_full_q) begin
            kbdr_d    = KB_DATA;
            kb_full_d = 1'b1;
        end else begin
            kbdr_d = kbdr_q;
        end

        if (dev_wr_s && (idx_q == IDX_KBSR)) begin
            kb_ie_d = MDR_IN[14];
        end else begin
            kb_ie_d = kb_ie_q;
        end
        if (dev_wr_s && (idx_q == IDX_DSR)) begin
            dsr_ie_d = MDR_IN[14];
        end else begin
            dsr_ie_d = dsr_ie_q;
        end

        // DISP_VALID is always the inverse of DSR ready, so these two never overlap
        if (dev_wr_s && (idx_q == IDX_DDR) && dsr_rdy_q) begin
            disp_data_d  = MDR_IN[7:0];
            dsr_rdy_d    = 1'b0;
            disp_valid_d = 1'b1;
        end else if (disp_valid_q && DISP_READY) begin
            disp_valid_d = 1'b0;
            dsr_rdy_d    = 1'b1;
        end else begin
            disp_valid_d = disp_valid_q;
        end

        kb_int_d   = kb_full_d & kb_ie_d;
        disp_int_d = dsr_rdy_d & dsr_ie_d;
    end

    // State and output registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            is_dev_q     <= 1'b0;
            idx_q        <= 2'd0;
            rw_q         <= 1'b0;
            r_q          <= 1'b0;
            mem_we_q     <= 1'b0;
            kb_full_q    <= 1'b0;
            kb_ie_q      <= 1'b0;
            kbdr_q       <= 8'h00;
            dsr_rdy_q    <= 1'b1;
            dsr_ie_q     <= 1'b0;
            disp_data_q  <= 8'h00;
            disp_valid_q <= 1'b0;
            kb_int_q     <= 1'b0;
            disp_int_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_dev_q     <= is_dev_d;
            idx_q        <= idx_d;
            rw_q         <= rw_d;
            r_q          <= r_d;
            mem_we_q     <= mem_we_d;
            kb_full_q    <= kb_full_d;
            kb_ie_q      <= kb_ie_d;
            kbdr_q       <= kbdr_d;
            dsr_rdy_q    <= dsr_rdy_d;
            dsr_ie_q     <= dsr_ie_d;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
            kb_int_q     <= kb_int_d;
            disp_int_q   <= disp_int_d;
        end
    end

    assign R          = r_q;
    assign MEM_WE     = mem_we_q;
    assign KBSR_OUT   = {kb_full_q, kb_ie_q, 14'd0};
    assign KBDR_OUT   = {8'd0, kbdr_q};
    assign DSR_OUT    = {dsr_rdy_q, dsr_ie_q, 14'd0};
    assign DISP_DATA  = disp_data_q;
    assign DISP_VALID = disp_valid_q;
    assign KB_INT     = kb_int_q;
    assign DISP_INT   = disp_int_q;

endmodule

// File: tb/tb_lc3_mmio_responder.sv
// Directed bench for lc3_mmio_responder: one instance at latency 2, one at latency 4.
module tb_lc3_mmio_responder;

    logic        clk;
    logic        rst_n;
    logic        mio_en;
    logic        mio_en4;
    logic        r_w;
    logic [15:0] mar;
    logic [15:0] mdr_in;
    logic [7:0]  kb_data;
    logic        kb_valid;
    logic        disp_ready;

    logic [1:0]  inmux_sel, inmux_sel4;
    logic        mem_en, mem_en4, mem_we, mem_we4, r, r4;
    logic [15:0] kbsr, kbsr4, kbdr, kbdr4, dsr, dsr4;
    logic        kb_ready, kb_ready4;
    logic [7:0]  disp_data, disp_data4;
    logic        disp_valid, disp_valid4;
    logic        kb_int, kb_int4, disp_int, disp_int4;

    int n_checks = 0;
    int n_err    = 0;

    lc3_mmio_responder #(.MEM_LATENCY(2)) dut (
        .CLK(clk), .RST_N(rst_n), .MIO_EN(mio_en), .R_W(r_w), .MAR(mar), .MDR_IN(mdr_in),
        .INMUX_SEL(inmux_sel), .MEM_EN(mem_en), .MEM_WE(mem_we), .R(r),
        .KBSR_OUT(kbsr), .KBDR_OUT(kbdr), .DSR_OUT(dsr),
        .KB_DATA(kb_data), .KB_VALID(kb_valid), .KB_READY(kb_ready),
        .DISP_DATA(disp_data), .DISP_VALID(disp_valid), .DISP_READY(disp_ready),
        .KB_INT(kb_int), .DISP_INT(disp_int)
    );

    lc3_mmio_responder #(.MEM_LATENCY(4)) dut4 (
        .CLK(clk), .RST_N(rst_n), .MIO_EN(mio_en4), .R_W(r_w), .MAR(mar), .MDR_IN(mdr_in),
        .INMUX_SEL(inmux_sel4), .MEM_EN(mem_en4), .MEM_WE(mem_we4), .R(r4),
        .KBSR_OUT(kbsr4), .KBDR_OUT(kbdr4), .DSR_OUT(dsr4),
        .KB_DATA(kb_data), .KB_VALID(kb_valid), .KB_READY(kb_ready4),
        .DISP_DATA(disp_data4), .DISP_VALID(disp_valid4), .DISP_READY(disp_ready),
        .KB_INT(kb_int4), .DISP_INT(disp_int4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One CPU access on the latency-2 instance, checking R arrives exactly lat cycles in
    task automatic access(input string tag, input logic [15:0] addr, input logic rw,
                          input logic [15:0] wdata, input int lat, input logic [1:0] exp_sel,
                          input logic exp_men, input logic exp_we);
        mar = addr; r_w = rw; mdr_in = wdata; mio_en = 1'b1;
        #1;
        chk({tag, ".sel"}, 16'(inmux_sel), 16'(exp_sel));
        chk({tag, ".mem_en"}, 16'(mem_en), 16'(exp_men));
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            chk({tag, ".r_early"}, 16'(r), 16'd0);
        end
        @(negedge clk);
        chk({tag, ".r"}, 16'(r), 16'd1);
        chk({tag, ".mem_we"}, 16'(mem_we), 16'(exp_we));
        mio_en = 1'b0; r_w = 1'b0;
        @(negedge clk);
        chk({tag, ".r_end"}, 16'(r), 16'd0);
        chk({tag, ".mem_we_end"}, 16'(mem_we), 16'd0);
    endtask

    initial begin
        rst_n = 1'b0; mio_en = 1'b0; mio_en4 = 1'b0; r_w = 1'b0;
        mar = 16'h0000; mdr_in = 16'h0000; kb_data = 8'h00; kb_valid = 1'b0; disp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset values
        chk("rst.dsr", dsr, 16'h8000);
        chk("rst.kbsr", kbsr, 16'h0000);
        chk("rst.kbdr", kbdr, 16'h0000);
        chk("rst.kb_ready", 16'(kb_ready), 16'd1);
        chk("rst.r", 16'(r), 16'd0);
        chk("rst.disp_valid", 16'(disp_valid), 16'd0);
        chk("rst.ints", {14'd0, kb_int, disp_int}, 16'd0);

        // Keyboard byte arrives
        kb_data = 8'h41; kb_valid = 1'b1;
        @(negedge clk);
        kb_valid = 1'b0;
        chk("kb1.kbsr", kbsr, 16'h8000);
        chk("kb1.kbdr", kbdr, 16'h0041);
        chk("kb1.kb_ready", 16'(kb_ready), 16'd0);

        // Read KBDR while x42 is already held valid
        kb_data = 8'h42; kb_valid = 1'b1;
        access("rd_kbdr", 16'hFE02, 1'b0, 16'h0000, 1, 2'b00, 1'b0, 1'b0);
        chk("rd_kbdr.kbsr_clr", kbsr, 16'h0000);
        chk("rd_kbdr.kb_ready", 16'(kb_ready), 16'd1);
        chk("rd_kbdr.kbdr_old", kbdr, 16'h0041);
        @(negedge clk);
        kb_valid = 1'b0;
        chk("kb2.kbsr", kbsr, 16'h8000);
        chk("kb2.kbdr", kbdr, 16'h0042);

        // Drain, ignored KBDR write, then keyboard interrupt
        access("drain", 16'hFE02, 1'b0, 16'h0000, 1, 2'b00, 1'b0, 1'b0);
        chk("drain.kbsr", kbsr, 16'h0000);
        access("wr_kbdr", 16'hFE02, 1'b1, 16'h0099, 1, 2'b00, 1'b0, 1'b0);
        chk("wr_kbdr.kbdr", kbdr, 16'h0042);
        access("wr_kbsr", 16'hFE00, 1'b1, 16'hFFFF & 16'h4000, 1, 2'b01, 1'b0, 1'b0);
        chk("wr_kbsr.kbsr", kbsr, 16'h4000);
        chk("wr_kbsr.kb_int", 16'(kb_int), 16'd0);
        kb_data = 8'h43; kb_valid = 1'b1;
        @(negedge clk);
        kb_valid = 1'b0;
        chk("kbint.kbsr", kbsr, 16'hC000);
        chk("kbint.kbdr", kbdr, 16'h0043);
        chk("kbint.kb_int", 16'(kb_int), 16'd1);

        // Display path
        access("wr_ddr1", 16'hFE06, 1'b1, 16'h1234, 1, 2'b11, 1'b0, 1'b0);
        chk("ddr1.data", 16'(disp_data), 16'h0034);
        chk("ddr1.valid", 16'(disp_valid), 16'd1);
        chk("ddr1.dsr", dsr, 16'h0000);
        access("wr_ddr2", 16'hFE06, 1'b1, 16'h0055, 1, 2'b11, 1'b0, 1'b0);
        chk("ddr2.data", 16'(disp_data), 16'h0034);
        chk("ddr2.valid", 16'(disp_valid), 16'd1);
        disp_ready = 1'b1;
        @(negedge clk);
        disp_ready = 1'b0;
        chk("drdy.dsr", dsr, 16'h8000);
        chk("drdy.valid", 16'(disp_valid), 16'd0);
        chk("drdy.data", 16'(disp_data), 16'h0034);
        access("rd_dsr", 16'hFE04, 1'b0, 16'h0000, 1, 2'b10, 1'b0, 1'b0);
        access("wr_dsr", 16'hFE04, 1'b1, 16'h4000, 1, 2'b10, 1'b0, 1'b0);
        chk("wr_dsr.dsr", dsr, 16'hC000);
        chk("wr_dsr.disp_int", 16'(disp_int), 16'd1);

        // Memory accesses at latency 2
        access("mem_rd2", 16'h3000, 1'b0, 16'h0000, 2, 2'b11, 1'b1, 1'b0);
        access("mem_wr2", 16'h3000, 1'b1, 16'hABCD, 2, 2'b11, 1'b1, 1'b1);

        // Memory read at latency 4
        mar = 16'h3000; r_w = 1'b0; mio_en4 = 1'b1;
        #1;
        chk("mem4.mem_en", 16'(mem_en4), 16'd1);
        chk("mem4.sel", 16'(inmux_sel4), 16'h0003);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mem4.r_early", 16'(r4), 16'd0);
        end
        @(negedge clk);
        chk("mem4.r", 16'(r4), 16'd1);
        mio_en4 = 1'b0;
        @(negedge clk);
        chk("mem4.r_end", 16'(r4), 16'd0);

        // Leave a display byte pending, then reset mid-WAIT of a latency-4 write
        access("wr_ddr3", 16'hFE06, 1'b1, 16'h0077, 1, 2'b11, 1'b0, 1'b0);
        chk("ddr3.data", 16'(disp_data), 16'h0077);
        chk("ddr3.dsr", dsr, 16'h4000);
        mar = 16'h3000; r_w = 1'b1; mio_en4 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midwait.r", 16'(r4), 16'd0);
        rst_n = 1'b0; mio_en4 = 1'b0; r_w = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("postrst.r4", 16'(r4), 16'd0);
            chk("postrst.we4", 16'(mem_we4), 16'd0);
        end
        chk("postrst.kbsr", kbsr, 16'h0000);
        chk("postrst.kbdr", kbdr, 16'h0000);
        chk("postrst.dsr", dsr, 16'h8000);
        chk("postrst.disp_valid", 16'(disp_valid), 16'd0);
        chk("postrst.disp_data", 16'(disp_data), 16'h0000);
        chk("postrst.ints", {14'd0, kb_int, disp_int}, 16'd0);
        chk("postrst.kb_ready", 16'(kb_ready), 16'd1);

        // Latency-4 instance back in IDLE: a fresh access keeps exact timing
        mar = 16'h3000; r_w = 1'b1; mio_en4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mem4b.r_early", 16'(r4), 16'd0);
        end
        @(negedge clk);
        chk("mem4b.r", 16'(r4), 16'd1);
        chk("mem4b.we", 16'(mem_we4), 16'd1);
        mio_en4 = 1'b0; r_w = 1'b0;
        @(negedge clk);
        chk("mem4b.r_end", 16'(r4), 16'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
